// File: rtl/sound_event_arbiter.sv
// Fixed-priority sound event arbiter: edge-detects event lines, plays the winner for a number of
// frames, then leaves a silence gap. Define SOUND_PENDING_EN to queue one lower-priority event.
module sound_event_arbiter #(
   parameter int unsigned N_EV        = 4,
   parameter int unsigned CODE_W      = 4,
   parameter int unsigned HOLD_FRAMES = 15,
   parameter int unsigned GAP_FRAMES  = 2,
   parameter int unsigned CNT_W       = 8,
   parameter logic [N_EV-1:0] STICKY_MASK = 4'b1100,
   localparam int unsigned IDX_W = (N_EV > 1) ? $clog2(N_EV) : 1
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic [N_EV-1:0]   event_in,
   input  logic              frame_start,
   output logic [CODE_W-1:0] sound_code,
   output logic              sound_active,
   output logic [IDX_W-1:0]  event_idx,
   output logic              play_done
);

   if (HOLD_FRAMES < 1) begin : g_bad_hold
      $error("sound_event_arbiter: HOLD_FRAMES must be >= 1");
   end

   typedef enum logic [1:0] {StIdle, StPlay, StGap, StSticky} state_e;

   state_e            state_q, state_d;
   logic [N_EV-1:0]   prev_q;
   logic [IDX_W-1:0]  cur_q, cur_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, gcnt_q, gcnt_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              active_q, done_q, done_d;
   logic [N_EV-1:0]   trig;
   logic              any_trig, load;
   logic [IDX_W-1:0]  cand, load_idx;
`ifdef SOUND_PENDING_EN
   logic              pend_valid_q, pend_valid_d;
   logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
`endif

   assign trig     = event_in & ~prev_q;
   assign any_trig = |trig;

   always_comb begin
      cand = '0;
      for (int i = 0; i < N_EV; i++) begin
         if (trig[i]) cand = IDX_W'(i);
      end
   end

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      cnt_d    = cnt_q;
      gcnt_d   = gcnt_q;
      done_d   = 1'b0;
      load     = 1'b0;
      load_idx = cand;
`ifdef SOUND_PENDING_EN
      pend_valid_d = pend_valid_q;
      pend_idx_d   = pend_idx_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (any_trig) load = 1'b1;
         end
         StPlay: begin
            // Equal or higher trigger reloads/preempts and beats a same-cycle timeout.
            if (any_trig && cand >= cur_q) begin
               load = 1'b1;
            end else begin
`ifdef SOUND_PENDING_EN
               if (any_trig && (!pend_valid_q || cand > pend_idx_q)) begin
                  pend_valid_d = 1'b1;
                  pend_idx_d   = cand;
               end
`endif
               if (frame_start) begin
                  if (cnt_q == CNT_W'(1)) begin
                     done_d = 1'b1;
                     if (GAP_FRAMES == 0) begin
                        state_d = StIdle;
`ifdef SOUND_PENDING_EN
                        if (pend_valid_d) begin
                           load         = 1'b1;
                           load_idx     = pend_idx_d;
                           pend_valid_d = 1'b0;
                        end
`endif
                     end else begin
                        state_d = StGap;
                        gcnt_d  = CNT_W'(GAP_FRAMES);
                     end
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
            end
         end
         StGap: begin
            if (any_trig) begin
               load = 1'b1;
            end else if (frame_start) begin
               if (gcnt_q <= CNT_W'(1)) begin
                  state_d = StIdle;
`ifdef SOUND_PENDING_EN
                  if (pend_valid_q) begin
                     load         = 1'b1;
                     load_idx     = pend_idx_q;
                     pend_valid_d = 1'b0;
                  end
`endif
               end else begin
                  gcnt_d = gcnt_q - CNT_W'(1);
               end
            end
         end
         StSticky: begin
            if (any_trig && cand > cur_q && STICKY_MASK[cand]) cur_d = cand;
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         cur_d = load_idx;
         if (STICKY_MASK[load_idx]) begin
            state_d = StSticky;
`ifdef SOUND_PENDING_EN
            pend_valid_d = 1'b0;
`endif
         end else begin
            state_d = StPlay;
            cnt_d   = CNT_W'(HOLD_FRAMES);
         end
      end

      // Outputs are registered from next state so a rise shows up on the same edge.
      if (state_d == StPlay || state_d == StSticky) code_d = CODE_W'(cur_d) + CODE_W'(1);
      else                                          code_d = '0;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= StIdle;
         prev_q   <= '0;
         cur_q    <= '0;
         cnt_q    <= '0;
         gcnt_q   <= '0;
         code_q   <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= event_in;
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         gcnt_q   <= gcnt_d;
         code_q   <= code_d;
         active_q <= (code_d != '0);
         done_q   <= done_d;
      end
   end

`ifdef SOUND_PENDING_EN
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pend_valid_q <= 1'b0;
         pend_idx_q   <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_idx_q   <= pend_idx_d;
      end
   end
`endif

   assign sound_code   = code_q;
   assign sound_active = active_q;
   assign event_idx    = cur_q;
   assign play_done    = done_q;

endmodule
